servo_seq_ctrl: RTL and testbench
=================================

# servo_seq_ctrl

Sequencer and PWM driver for the laser pan servo in the clap-controlled pointer. Takes one-cycle clap events with a 2-bit side code (`lado`) from the clap detector, slews the servo pulse width toward the commanded position one step per 20 ms frame, holds there, then returns home. Internally generates the 50 Hz servo PWM, so it replaces direct pulse-width selection in the top level.

## Interface
- `FRAME_CYC`, 1_000_000: clock cycles per PWM frame (20 ms at 50 MHz).
- `W_HOME`, 25_000: home pulse width in cycles (0.5 ms, 0°).
- `W_LEFT`, 50_000: left pulse width (45°).
- `W_CENTER`, 75_000: center pulse width (90°).
- `W_RIGHT`, 100_000: right pulse width (135°).
- `STEP`, 1_250: maximum width change per frame.
- `HOLD_FRAMES`, 100: frames spent at target before returning (2 s).

Ports:
- `CLK`  in  1  system clock, single clock domain.
- `RST_N`  in  1  reset, asynchronous assert, active-low.
- `clap`  in  1  one-cycle clap event.
- `lado`  in  2  side code, sampled with `clap`: 0 center, 1 left, 2 right, 3 invalid.
- `pwm`  out  1  servo PWM, registered.
- `width`  out  20  current pulse width in cycles.
- `frame_tick`  out  1  one-cycle strobe on the last cycle of each frame.
- `busy`  out  1  high in every state except IDLE.
- `at_target`  out  1  high when `width` equals the target.

## Operation
- Reset values: state IDLE, target `W_HOME`, `width` `W_HOME`, frame counter 0, `pwm` 0, `frame_tick` 0, `busy` 0, `at_target` 1, hold counter 0.
- States:
  - IDLE: target is `W_HOME`.
  - MOVE: slew toward the latched side target.
  - HOLD: count frames.
  - RETURN: slew toward `W_HOME`.
- Transitions:
  - IDLE + valid clap goes to MOVE, latching the target from `lado`.
  - MOVE goes to HOLD once `width == target`; the hold counter clears.
  - HOLD goes to RETURN after `HOLD_FRAMES` frame ticks.
  - RETURN goes to IDLE once `width == W_HOME`.
- Clap handling:
  - A clap with `lado == 3` is dropped in every state.
  - A valid clap in HOLD or RETURN retargets: target is reloaded, state goes to MOVE, and the hold counter clears.
  - A clap in MOVE is ignored.
- Slew: `width` updates only on a `frame_tick` cycle. If `|target − width| <= STEP`, then `width = target`; otherwise `width` moves ±`STEP` toward the target. Compare before subtracting so that no unsigned wrap occurs.
- PWM: the frame counter runs 0..`FRAME_CYC−1` and wraps. `pwm` is registered from `(cnt < width)`.

## Timing
- A clap sampled at edge N changes state and target at edge N. `busy` rises one cycle after the clap.
- The first width change happens at the next `frame_tick`, so latency from clap to first motion is at most one frame.
- `width` changes only on the edge that ends a frame, so every frame uses a single constant width.
- `pwm` lags the counter compare by one cycle. The high time per frame equals `width` cycles exactly.
- If a clap and `frame_tick` occur in the same cycle, the step uses the pre-edge target and the new target applies from the next frame.
- The HOLD count includes the tick on which it reaches `HOLD_FRAMES`.
- Asserting `RST_N` mid-move forces all reset values immediately.

## Configuration
- `SERVO_AUTO_RETURN_EN` defined: full HOLD/RETURN behaviour as above.
- Not defined: HOLD and RETURN are not compiled in. MOVE goes to IDLE at target, and `width` stays at the side position until the next valid clap. `busy` is low while parked, and `HOLD_FRAMES` is unused.

## Structure
- Package `servo_pkg` holds:
  - the width constant (20), the `lado` encodings, and the state enum;
  - the default width and frame constants.
- Sub-module `servo_pwm_gen` contains the frame counter, `frame_tick`, and the registered comparator. The sequencer and slew logic stay in `servo_seq_ctrl`.

## Test plan
All scenarios run with `FRAME_CYC=1000`, `STEP=1250`, `HOLD_FRAMES=4`.
- Reset, then idle for 3 frames. Expected: `pwm` high exactly 25_000 cycles per frame is impossible at `FRAME_CYC=1000`, so the bench overrides `W_HOME=200`. `pwm` must then be high 200 cycles per frame, with `busy=0` and `at_target=1`.
- Overrides `W_HOME=200`, `W_RIGHT=700`, `STEP=200`. Clap with `lado=2`. Expected widths on successive frames: 400, 600, 700. HOLD lasts 4 frames; RETURN then gives 500, 300, 200; IDLE follows with `busy` falling.
- Clap with `lado=3` in IDLE. Expected: no state change, `busy` stays 0, `width` unchanged.
- During HOLD at right (700), clap with `lado=1` (`W_LEFT=300`). Expected: MOVE, widths 500, 300, then the hold count restarts from 0.
- Clap asserted in the same cycle as `frame_tick` from IDLE. Expected: that frame's width is still 200 and motion starts on the following tick. Asserting `RST_N=0` mid-move must give `width=W_HOME` and `pwm=0` immediately.
- Build without `SERVO_AUTO_RETURN_EN`, then clap right. Expected: `width` stays at 700 for 10 frames and `busy=0` after arrival.

Source files
------------

// File: rtl/servo_pkg.sv
// servo_pkg: shared types and defaults for the laser pan servo sequencer.
// Holds the pulse-width datapath width, lado side codes, the sequencer state
// enum, the default frame/width constants and the per-frame slew helper.
package servo_pkg;

  localparam int WIDTH_W = 20;

  localparam logic [1:0] LADO_CENTER  = 2'd0;
  localparam logic [1:0] LADO_LEFT    = 2'd1;
  localparam logic [1:0] LADO_RIGHT   = 2'd2;
  localparam logic [1:0] LADO_INVALID = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MOVE   = 2'd1,
    S_HOLD   = 2'd2,
    S_RETURN = 2'd3
  } state_t;

  localparam int DEF_FRAME_CYC   = 1_000_000;
  localparam int DEF_W_HOME      = 25_000;
  localparam int DEF_W_LEFT      = 50_000;
  localparam int DEF_W_CENTER    = 75_000;
  localparam int DEF_W_RIGHT     = 100_000;
  localparam int DEF_STEP        = 1_250;
  localparam int DEF_HOLD_FRAMES = 100;

  // One slew step from cur toward tgt, limited to step. The direction is
  // decided before any subtraction so the unsigned difference never wraps.
  function automatic logic [WIDTH_W-1:0] slew_step(
    input logic [WIDTH_W-1:0] cur,
    input logic [WIDTH_W-1:0] tgt,
    input logic [WIDTH_W-1:0] step
  );
    logic [WIDTH_W-1:0] res;
    if (tgt >= cur) begin
      res = ((tgt - cur) <= step) ? tgt : (cur + step);
    end else begin
      res = ((cur - tgt) <= step) ? tgt : (cur - step);
    end
    return res;
  endfunction

endpackage

// File: rtl/servo_pwm_gen.sv
// servo_pwm_gen: free-running frame counter, end-of-frame strobe and the
// registered width comparator that produces the servo pulse.
module servo_pwm_gen
  import servo_pkg::*;
#(
  parameter int FRAME_CYC = DEF_FRAME_CYC
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [WIDTH_W-1:0] width,
  output logic               pwm,
  output logic               frame_tick
);

  localparam logic [WIDTH_W-1:0] CNT_LAST = WIDTH_W'(FRAME_CYC - 1);

  logic [WIDTH_W-1:0] cnt;

  // Frame counter wraps at FRAME_CYC-1; pwm is the compare delayed one cycle,
  // so cycles 1..width of each frame are high (exactly width cycles).
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt <= '0;
      pwm <= 1'b0;
    end else begin
      cnt <= (cnt == CNT_LAST) ? '0 : (cnt + WIDTH_W'(1));
      pwm <= (cnt < width);
    end
  end

  // Strobe on the last cycle of the frame; the width register updates on
  // the edge that ends this cycle.
  assign frame_tick = (cnt == CNT_LAST);

endmodule

// File: rtl/servo_seq_ctrl.sv
// servo_seq_ctrl: clap-driven pan servo sequencer with internal 50 Hz PWM.
// Optional feature macro: SERVO_AUTO_RETURN_EN (adds HOLD/RETURN auto-homing;
// without it the servo parks at the side position until the next clap).
//
// Handshake: clap is a valid-only one-cycle strobe with no ready/backpressure;
// lado is qualified by clap in the same cycle. A clap the current state does
// not act on (lado invalid, or any clap during MOVE) is dropped, not queued.
module servo_seq_ctrl
  import servo_pkg::*;
#(
  parameter int FRAME_CYC   = DEF_FRAME_CYC,
  parameter int W_HOME      = DEF_W_HOME,
  parameter int W_LEFT      = DEF_W_LEFT,
  parameter int W_CENTER    = DEF_W_CENTER,
  parameter int W_RIGHT     = DEF_W_RIGHT,
  parameter int STEP        = DEF_STEP,
  parameter int HOLD_FRAMES = DEF_HOLD_FRAMES
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               clap,
  input  logic [1:0]         lado,
  output logic               pwm,
  output logic [WIDTH_W-1:0] width,
  output logic               frame_tick,
  output logic               busy,
  output logic               at_target,
  output state_t             dbg_state
);

  localparam logic [WIDTH_W-1:0] HOME_W   = WIDTH_W'(W_HOME);
  localparam logic [WIDTH_W-1:0] LEFT_W   = WIDTH_W'(W_LEFT);
  localparam logic [WIDTH_W-1:0] CENTER_W = WIDTH_W'(W_CENTER);
  localparam logic [WIDTH_W-1:0] RIGHT_W  = WIDTH_W'(W_RIGHT);
  localparam logic [WIDTH_W-1:0] STEP_W   = WIDTH_W'(STEP);

`ifdef SERVO_AUTO_RETURN_EN
  localparam int HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_n;
`endif

  state_t             state;
  state_t             state_n;
  logic [WIDTH_W-1:0] target;
  logic [WIDTH_W-1:0] target_n;
  logic [WIDTH_W-1:0] width_n;
  logic [WIDTH_W-1:0] side_w;
  logic               valid_clap;

  // Decode the side code into its pulse width.
  always_comb begin
    side_w = CENTER_W;
    case (lado)
      LADO_LEFT:  side_w = LEFT_W;
      LADO_RIGHT: side_w = RIGHT_W;
      default:    side_w = CENTER_W;
    endcase
  end

  // Next-state, target and slew. The slew uses the pre-edge target, so a clap
  // coinciding with frame_tick only affects motion from the next frame on.
  always_comb begin
    valid_clap = clap && (lado != LADO_INVALID);
    state_n    = state;
    target_n   = target;
    width_n    = frame_tick ? slew_step(width, target, STEP_W) : width;
`ifdef SERVO_AUTO_RETURN_EN
    hold_n     = hold_cnt;
`endif
    case (state)
      S_IDLE: begin
        if (valid_clap) begin
          state_n  = S_MOVE;
          target_n = side_w;
        end
      end
      S_MOVE: begin
        if (width == target) begin
`ifdef SERVO_AUTO_RETURN_EN
          state_n = S_HOLD;
          hold_n  = '0;
`else
          state_n = S_IDLE;
`endif
        end
      end
`ifdef SERVO_AUTO_RETURN_EN
      S_HOLD: begin
        if (valid_clap) begin
          state_n  = S_MOVE;
          target_n = side_w;
          hold_n   = '0;
        end else if (frame_tick) begin
          if (hold_cnt == HOLD_LAST) begin
            state_n  = S_RETURN;
            target_n = HOME_W;
          end else begin
            hold_n = hold_cnt + 1'b1;
          end
        end
      end
      S_RETURN: begin
        if (valid_clap) begin
          state_n  = S_MOVE;
          target_n = side_w;
          hold_n   = '0;
        end else if (width == HOME_W) begin
          state_n = S_IDLE;
        end
      end
`endif
      default: state_n = S_IDLE;
    endcase
  end

  // Sequencer registers; busy is registered from the next state so it rises
  // one cycle after the accepted clap.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= S_IDLE;
      target <= HOME_W;
      width  <= HOME_W;
      busy   <= 1'b0;
`ifdef SERVO_AUTO_RETURN_EN
      hold_cnt <= '0;
`endif
    end else begin
      state  <= state_n;
      target <= target_n;
      width  <= width_n;
      busy   <= (state_n != S_IDLE);
`ifdef SERVO_AUTO_RETURN_EN
      hold_cnt <= hold_n;
`endif
    end
  end

  assign at_target = (width == target);
  assign dbg_state = state;

  servo_pwm_gen #(
    .FRAME_CYC(FRAME_CYC)
  ) u_pwm (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .width     (width),
    .pwm       (pwm),
    .frame_tick(frame_tick)
  );

endmodule

// File: tb/tb_servo_seq_ctrl.sv
// tb_servo_seq_ctrl: directed bench for servo_seq_ctrl with small frames.
// Covers both builds; the SERVO_AUTO_RETURN_EN macro selects the middle part.
module tb_servo_seq_ctrl;
  import servo_pkg::*;

  localparam int FRAME  = 1000;
  localparam int HOME   = 200;
  localparam int LEFT   = 300;
  localparam int CENTER = 450;
  localparam int RIGHT  = 700;
  localparam int STEPV  = 200;
  localparam int HOLD   = 4;

  // ---------------- clock / reset / DUT ----------------
  logic         CLK   = 1'b0;
  logic         RST_N = 1'b0;
  logic         clap  = 1'b0;
  logic [1:0]   lado  = 2'd0;
  logic         pwm;
  logic [19:0]  width;
  logic         frame_tick;
  logic         busy;
  logic         at_target;
  state_t       dbg_state;

  always #5 CLK = ~CLK;

  servo_seq_ctrl #(
    .FRAME_CYC  (FRAME),
    .W_HOME     (HOME),
    .W_LEFT     (LEFT),
    .W_CENTER   (CENTER),
    .W_RIGHT    (RIGHT),
    .STEP       (STEPV),
    .HOLD_FRAMES(HOLD)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .clap      (clap),
    .lado      (lado),
    .pwm       (pwm),
    .width     (width),
    .frame_tick(frame_tick),
    .busy      (busy),
    .at_target (at_target),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [19:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance to the negedge of the next frame_tick cycle, bounded.
  task automatic wait_tick();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < FRAME + 5; i++) begin
      @(negedge CLK);
      if (frame_tick === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check("tick_seen", seen, 1);
  endtask

  // Width of the frame that starts after the next tick; ends at its cnt=0.
  task automatic next_width(output logic [19:0] w);
    wait_tick();
    @(negedge CLK);
    w = width;
  endtask

  task automatic check_frames(input string tag, input int n);
    logic [19:0] w;
    logic [19:0] e;
    for (int i = 0; i < n; i++) begin
      next_width(w);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      check(tag, w, e);
    end
  endtask

  // High cycles of one complete frame; ends at cnt=0 of the frame after.
  task automatic measure(output int hi);
    wait_tick();
    hi = 0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge CLK);
      if (pwm === 1'b1) hi++;
    end
    @(negedge CLK);
  endtask

  task automatic do_clap(input logic [1:0] v);
    clap = 1'b1;
    lado = v;
    @(negedge CLK);
    clap = 1'b0;
    lado = $urandom_range(0, 3);
  endtask

  task automatic clap_on_tick(input logic [1:0] v);
    wait_tick();
    do_clap(v);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int          hi;
    logic [19:0] w;
    int          tail_start;
    int          tail_next;

    repeat (3) @(negedge CLK);
    check("rst_width", width, HOME);
    check("rst_pwm", pwm, 0);
    check("rst_tick", frame_tick, 0);
    check("rst_busy", busy, 0);
    check("rst_at_target", at_target, 1);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
    RST_N = 1'b1;

    for (int f = 0; f < 3; f++) begin
      measure(hi);
      check("idle_pwm_hi", hi, HOME);
      check("idle_busy", busy, 0);
      check("idle_at_target", at_target, 1);
    end

    repeat (10) @(negedge CLK);
    do_clap(LADO_INVALID);
    check("drop_busy", busy, 0);
    check("drop_state", 32'(dbg_state), 32'(S_IDLE));
    next_width(w);
    check("drop_width", w, HOME);

    repeat (17) @(negedge CLK);
    do_clap(LADO_RIGHT);
    exp_q.push_back(20'd400);
    exp_q.push_back(20'd600);
    exp_q.push_back(20'd700);
    check("clap_busy", busy, 1);
    check("clap_state", 32'(dbg_state), 32'(S_MOVE));
    check("clap_at_target", at_target, 0);
    check_frames("move_right", 1);
    do_clap(LADO_LEFT);
    check("move_ignore_state", 32'(dbg_state), 32'(S_MOVE));
    check_frames("move_right", 2);
    @(negedge CLK);

`ifdef SERVO_AUTO_RETURN_EN
    check("hold_state", 32'(dbg_state), 32'(S_HOLD));
    check("hold_busy", busy, 1);
    for (int i = 0; i < HOLD; i++) exp_q.push_back(20'd700);
    exp_q.push_back(20'd500);
    exp_q.push_back(20'd300);
    exp_q.push_back(20'd200);
    check_frames("hold_return", HOLD + 3);
    @(negedge CLK);
    check("home_state", 32'(dbg_state), 32'(S_IDLE));
    check("home_busy", busy, 0);
    check("home_at_target", at_target, 1);

    do_clap(LADO_RIGHT);
    exp_q.push_back(20'd400);
    exp_q.push_back(20'd600);
    exp_q.push_back(20'd700);
    exp_q.push_back(20'd700);
    check_frames("move_right2", 4);
    check("hold2_state", 32'(dbg_state), 32'(S_HOLD));
    do_clap(LADO_LEFT);
    check("retarget_state", 32'(dbg_state), 32'(S_MOVE));
    exp_q.push_back(20'd500);
    exp_q.push_back(20'd300);
    for (int i = 0; i < HOLD; i++) exp_q.push_back(20'd300);
    exp_q.push_back(20'd200);
    check_frames("retarget_left", HOLD + 3);
    @(negedge CLK);
    check("home2_state", 32'(dbg_state), 32'(S_IDLE));
    check("home2_busy", busy, 0);
    tail_start = HOME;
    tail_next  = 400;
`else
    check("park_state", 32'(dbg_state), 32'(S_IDLE));
    check("park_busy", busy, 0);
    check("park_at_target", at_target, 1);
    for (int i = 0; i < 10; i++) exp_q.push_back(20'd700);
    check_frames("park_width", 10);
    check("park_busy2", busy, 0);
    measure(hi);
    check("park_pwm_hi", hi, RIGHT);
    do_clap(LADO_LEFT);
    check("left_state", 32'(dbg_state), 32'(S_MOVE));
    exp_q.push_back(20'd500);
    exp_q.push_back(20'd300);
    check_frames("move_left", 2);
    @(negedge CLK);
    check("left_park_busy", busy, 0);
    tail_start = LEFT;
    tail_next  = 500;
`endif

    // Clap in the frame_tick cycle: this frame keeps the old width.
    clap_on_tick(LADO_RIGHT);
    check("tick_clap_width", width, tail_start);
    check("tick_clap_state", 32'(dbg_state), 32'(S_MOVE));
    check("tick_clap_busy", busy, 1);
    next_width(w);
    check("tick_clap_next", w, tail_next);

    // Asynchronous reset mid-move, while the pulse is high.
    repeat (50) @(negedge CLK);
    check("pre_rst_pwm", pwm, 1);
    RST_N = 1'b0;
    #1;
    check("mid_rst_width", width, HOME);
    check("mid_rst_pwm", pwm, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_state", 32'(dbg_state), 32'(S_IDLE));
    check("mid_rst_at_target", at_target, 1);
    @(negedge CLK);
    RST_N = 1'b1;
    next_width(w);
    check("post_rst_width", w, HOME);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
